// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: MSB-first 8-bit frames from a valid/ready host port,
// with internally divided sclk and cs held low across back-to-back bytes.
module spi_master_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_busy,
    output logic       o_cs,
    output logic       o_sclk,
    output logic       o_mosi,
    input  logic       i_miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [3:0] r_bitcnt;
    logic [3:0] w_bitcnt_next;
    logic [6:0] r_tx_shift;
    logic [6:0] w_tx_shift_next;
    logic [7:0] r_rx_shift;
    logic [7:0] w_rx_shift_next;
    logic [7:0] r_rx_data;
    logic [7:0] w_rx_data_next;
    logic       r_rx_valid;
    logic       w_rx_valid_next;
    logic       r_cs;
    logic       w_cs_next;
    logic       r_sclk;
    logic       w_sclk_next;
    logic       r_mosi;
    logic       w_mosi_next;

    logic       w_tx_ready;
    logic       w_accept;
    logic       w_cnt_last;

    assign w_tx_ready = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign w_accept   = i_tx_valid && w_tx_ready;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_bitcnt_next   = r_bitcnt;
        w_tx_shift_next = r_tx_shift;
        w_rx_shift_next = r_rx_shift;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_cs_next       = r_cs;
        w_sclk_next     = r_sclk;
        w_mosi_next     = r_mosi;

        case (r_state)
            S_IDLE: begin
                w_cs_next   = 1'b1;
                w_sclk_next = 1'b0;
                if (w_accept) begin
                    w_tx_shift_next = i_tx_data[6:0];
                    w_mosi_next     = i_tx_data[7];
                    w_cs_next       = 1'b0;
                    w_cnt_next      = 8'd0;
                    w_bitcnt_next   = 4'd0;
                    w_state_next    = S_SETUP;
                end
            end

            S_SETUP: begin
                if (w_cnt_last) begin
                    w_cnt_next   = 8'd0;
                    w_state_next = S_XFER;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end

            S_XFER: begin
                if (w_cnt_last) begin
                    w_cnt_next  = 8'd0;
                    w_sclk_next = ~r_sclk;
                    if (!r_sclk) begin
                        // Rising edge: slave data is stable, sample it.
                        w_rx_shift_next = {r_rx_shift[6:0], i_miso};
                    end else begin
                        w_bitcnt_next = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            // Last falling edge: mosi is left at bit 0.
                            w_rx_data_next  = r_rx_shift;
                            w_rx_valid_next = 1'b1;
                            w_state_next    = S_HOLD;
                        end else begin
                            w_mosi_next     = r_tx_shift[6];
                            w_tx_shift_next = {r_tx_shift[5:0], 1'b0};
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end

            S_HOLD: begin
                w_sclk_next = 1'b0;
                if (w_accept) begin
                    // Burst continuation: skip SETUP, cs never rises.
                    w_tx_shift_next = i_tx_data[6:0];
                    w_mosi_next     = i_tx_data[7];
                    w_bitcnt_next   = 4'd0;
                    w_cnt_next      = 8'd0;
                    w_state_next    = S_XFER;
                end else if (w_cnt_last) begin
                    w_cs_next    = 1'b1;
                    w_cnt_next   = 8'd0;
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end

            S_GAP: begin
                if (w_cnt_last) begin
                    w_cnt_next   = 8'd0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cs_next    = 1'b1;
                w_sclk_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= 8'd0;
            r_bitcnt   <= 4'd0;
            r_tx_shift <= 7'd0;
            r_rx_shift <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_bitcnt   <= w_bitcnt_next;
            r_tx_shift <= w_tx_shift_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid_next;
            r_cs       <= w_cs_next;
            r_sclk     <= w_sclk_next;
            r_mosi     <= w_mosi_next;
        end
    end

    assign o_tx_ready = w_tx_ready;
    assign o_busy     = (r_state != S_IDLE);
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_cs       = r_cs;
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: DIV=4 and DIV=2 instances share stimulus; a bus monitor
// logs edge timing and a byte-level slave model supplies miso.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       sel;          // 0: DIV=4 instance, 1: DIV=2 instance
    logic       loopback;
    logic       reset_phase;
    logic       rand_miso;
    logic       slave_miso;
    logic       miso;

    logic       tx_ready4, rx_valid4, busy4, cs4, sclk4, mosi4;
    logic [7:0] rx_data4;
    logic       tx_ready2, rx_valid2, busy2, cs2, sclk2, mosi2;
    logic [7:0] rx_data2;

    logic       tx_ready, rx_valid, busy, cs, sclk, mosi;
    logic [7:0] rx_data;

    spi_master_ctrl #(.DIV(4)) u_dut4 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid & ~sel),
        .o_tx_ready (tx_ready4),
        .o_rx_data  (rx_data4),
        .o_rx_valid (rx_valid4),
        .o_busy     (busy4),
        .o_cs       (cs4),
        .o_sclk     (sclk4),
        .o_mosi     (mosi4),
        .i_miso     (miso)
    );

    spi_master_ctrl #(.DIV(2)) u_dut2 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid & sel),
        .o_tx_ready (tx_ready2),
        .o_rx_data  (rx_data2),
        .o_rx_valid (rx_valid2),
        .o_busy     (busy2),
        .o_cs       (cs2),
        .o_sclk     (sclk2),
        .o_mosi     (mosi2),
        .i_miso     (miso)
    );

    assign tx_ready = sel ? tx_ready2 : tx_ready4;
    assign rx_valid = sel ? rx_valid2 : rx_valid4;
    assign rx_data  = sel ? rx_data2  : rx_data4;
    assign busy     = sel ? busy2     : busy4;
    assign cs       = sel ? cs2       : cs4;
    assign sclk     = sel ? sclk2     : sclk4;
    assign mosi     = sel ? mosi2     : mosi4;
    assign miso     = reset_phase ? rand_miso : (loopback ? mosi : slave_miso);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus monitor and slave model ----------------
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         rise_cyc[$];
    logic       mosi_at_rise[$];
    int         rxv_cyc[$];
    logic [7:0] rxv_data[$];
    int         cs_rise_cyc[$];
    int         busy_fall_cyc[$];
    int         rxv_consec = 0;
    logic [7:0] slave_q[$];
    logic [7:0] sl_bits = 8'h00;
    int         sl_cnt = 0;
    logic       sclk_prev = 1'b0, rxv_prev = 1'b0, cs_prev = 1'b1, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (sclk && !sclk_prev) begin
            rise_cyc.push_back(cyc);
            mosi_at_rise.push_back(mosi);
        end
        if (rx_valid) begin
            rxv_cyc.push_back(cyc);
            rxv_data.push_back(rx_data);
            if (rxv_prev) rxv_consec++;
        end
        if (cs && !cs_prev) cs_rise_cyc.push_back(cyc);
        if (!busy && busy_prev) busy_fall_cyc.push_back(cyc);
        // Mode-0 slave: first bit valid while cs is high, next bit after each sclk fall.
        if (cs) begin
            sl_cnt  = 0;
            sl_bits = (slave_q.size() > 0) ? slave_q[0] : 8'h00;
        end else if (sclk_prev && !sclk) begin
            sl_cnt++;
            if (sl_cnt == 8) begin
                if (slave_q.size() > 0) void'(slave_q.pop_front());
                sl_cnt  = 0;
                sl_bits = (slave_q.size() > 0) ? slave_q[0] : 8'h00;
            end else begin
                sl_bits = {sl_bits[6:0], 1'b0};
            end
        end
        slave_miso = sl_bits[7];
        sclk_prev  = sclk;
        rxv_prev   = rx_valid;
        cs_prev    = cs;
        busy_prev  = busy;
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [15:0] mosi_word(input int first, input int n);
        logic [15:0] w = 16'h0;
        for (int i = first; i < first + n; i++)
            w = {w[14:0], (i < mosi_at_rise.size()) ? mosi_at_rise[i] : 1'b0};
        return w;
    endfunction

    function automatic int bad_periods(input int div);
        int bad = 0;
        for (int i = 1; i < rise_cyc.size(); i++)
            if (rise_cyc[i] - rise_cyc[i-1] != 2 * div) bad++;
        return bad;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rise_cyc.delete();
        mosi_at_rise.delete();
        rxv_cyc.delete();
        rxv_data.delete();
        cs_rise_cyc.delete();
        busy_fall_cyc.delete();
    endtask

    task automatic wait_rxv(input int n, input int budget);
        int t = 0;
        while (rxv_cyc.size() < n && t < budget) begin
            tick();
            t++;
        end
        check("rxv_arrived", 32'(rxv_cyc.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy_fall_cyc.size() < 1 && t < budget) begin
            tick();
            t++;
        end
        check("busy_fell", 32'(busy_fall_cyc.size() >= 1), 32'd1);
    endtask

    // Single byte from IDLE, checked against frame-level timing rules.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] sl);
        int div, acc, rv;
        logic [7:0] exp_rx;
        div = sel ? 2 : 4;
        clear_logs();
        slave_q.delete();
        slave_q.push_back(sl);
        exp_rx = loopback ? tx : sl;
        tick();
        check("tx_ready_idle", 32'(tx_ready), 32'd1);
        tx_data  = tx;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        acc      = cyc;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        wait_rxv(1, 20 * div);
        rv = qget(rxv_cyc, 0);
        check("rx_latency", 32'(rv - acc), 32'(17 * div));
        check("rx_data", 32'((rxv_data.size() > 0) ? rxv_data[0] : 8'hxx), 32'(exp_rx));
        check("first_rise", 32'(qget(rise_cyc, 0) - acc), 32'(2 * div));
        check("rise_count", 32'(rise_cyc.size()), 32'd8);
        check("mosi_bits", 32'(mosi_word(0, 8)), 32'(tx));
        check("sclk_period", 32'(bad_periods(div)), 32'd0);
        wait_idle(8 * div);
        check("cs_rise_after_rxv", 32'(qget(cs_rise_cyc, 0) - rv), 32'(div));
        check("busy_low_after_rxv", 32'(qget(busy_fall_cyc, 0) - rv), 32'(2 * div));
        check("rxv_once", 32'(rxv_cyc.size()), 32'd1);
        $display("xfer div=%0d tx=%02h rx=%02h expect=%02h", div, tx,
                 (rxv_data.size() > 0) ? rxv_data[0] : 8'h00, exp_rx);
    endtask

    // Two bytes: host keeps tx_valid high with the second byte through the first XFER.
    task automatic burst(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] sa, input logic [7:0] sb);
        int div, acc1, acc2, rv1, rv2, t;
        div = sel ? 2 : 4;
        clear_logs();
        slave_q.delete();
        slave_q.push_back(sa);
        slave_q.push_back(sb);
        tick();
        tx_data  = a;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        acc1    = cyc;
        tx_data = b;
        t = 0;
        do begin
            tick();
            t++;
        end while (!tx_ready && t < 20 * div);
        rv1 = qget(rxv_cyc, 0);
        check("ready_first_hold", 32'(cyc - rv1), 32'd0);
        check("rx1_latency", 32'(rv1 - acc1), 32'(17 * div));
        @(posedge clk);
        #1;
        acc2     = cyc;
        tx_valid = 1'b0;
        check("hold_accept", 32'(acc2 - rv1), 32'd1);
        wait_rxv(2, 20 * div);
        rv2 = qget(rxv_cyc, 1);
        check("rx2_latency", 32'(rv2 - acc2), 32'(16 * div));
        check("strobe_gap", 32'(rv2 - rv1), 32'(16 * div + 1));
        check("burst_rx0", 32'((rxv_data.size() > 0) ? rxv_data[0] : 8'hxx), 32'(sa));
        check("burst_rx1", 32'((rxv_data.size() > 1) ? rxv_data[1] : 8'hxx), 32'(sb));
        check("burst_rises", 32'(rise_cyc.size()), 32'd16);
        check("burst_cs_low", 32'(cs_rise_cyc.size()), 32'd0);
        check("burst_mosi", 32'(mosi_word(0, 16)), 32'({a, b}));
        wait_idle(8 * div);
        check("burst_cs_rise", 32'(qget(cs_rise_cyc, 0) - rv2), 32'(div));
        $display("burst div=%0d tx=%02h,%02h rx=%02h,%02h", div, a, b,
                 (rxv_data.size() > 0) ? rxv_data[0] : 8'h00,
                 (rxv_data.size() > 1) ? rxv_data[1] : 8'h00);
    endtask

    task automatic reset_abort();
        int div;
        div = sel ? 2 : 4;
        clear_logs();
        slave_q.delete();
        slave_q.push_back(8'hC3);
        tick();
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int t = 0; t < 20 * div && rise_cyc.size() < 3; t++) tick();
        check("third_rise_seen", 32'(rise_cyc.size()), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 20 * div; t++) tick();
        check("abort_no_rxv", 32'(rxv_cyc.size()), 32'd0);
        $display("reset abort div=%0d after %0d rises", div, rise_cyc.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        sel         = 1'b0;
        loopback    = 1'b0;
        reset_phase = 1'b1;
        rand_miso   = 1'b0;

        for (int i = 0; i < 4; i++) begin
            tx_data   = 8'($urandom);
            tx_valid  = 1'($urandom);
            rand_miso = 1'($urandom);
            tick();
            for (int s = 0; s < 2; s++) begin
                sel = 1'(s);
                #1;
                check("reset_outputs", 32'({cs, sclk, mosi, rx_valid, busy, tx_ready, rx_data}),
                      32'(14'b1_0_0_0_0_1_00000000));
            end
            $display("reset cycle %0d checked on both instances", i);
        end
        tx_valid    = 1'b0;
        reset_phase = 1'b0;
        sel         = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        xfer(8'hA5, 8'h3C);
        for (int i = 0; i < 3; i++) xfer(8'($urandom), 8'($urandom));

        burst(8'h11, 8'h22, 8'($urandom), 8'($urandom));
        burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        reset_abort();
        xfer(8'($urandom), 8'($urandom));

        sel      = 1'b1;
        loopback = 1'b1;
        tick();
        xfer(8'h00, 8'h00);
        xfer(8'hFF, 8'h00);
        xfer(8'h81, 8'h00);
        xfer(8'($urandom), 8'h00);
        loopback = 1'b0;
        burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        check("rxv_never_consecutive", 32'(rxv_consec), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
